// File: rtl/ahb_rr_matrix.sv
// ahb_rr_matrix: AHB-Lite multi-master/multi-slave interconnect with per-slave round-robin,
// per-master pending-request buffers, locked-slave hold and an internal default ERROR slave.
// Ports:
//   HCLK, HRESET      bus clock, asynchronous active-high reset
//   m_haddr..m_hwdata master address/control/write data in (slice i = master i)
//   m_hrdata/hready/hresp  response to each master
//   s_hsel..s_hwdata  forwarded phase to each slave (slice j = slave j), s_haddr slave-relative
//   s_hready          HREADY input of each slave
//   s_hreadyout/hresp/hrdata  response from each slave
module ahb_rr_matrix #(
   parameter int NUM_MASTER = 2,
   parameter int NUM_SLAVES = 8,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_LAST = '0
) (
   input  logic                             HCLK,
   input  logic                             HRESET,
   input  logic [NUM_MASTER*ADDR_WIDTH-1:0] m_haddr,
   input  logic [NUM_MASTER*2-1:0]          m_htrans,
   input  logic [NUM_MASTER-1:0]            m_hwrite,
   input  logic [NUM_MASTER*3-1:0]          m_hsize,
   input  logic [NUM_MASTER*3-1:0]          m_hburst,
   input  logic [NUM_MASTER*4-1:0]          m_hprot,
   input  logic [NUM_MASTER-1:0]            m_hmastlock,
   input  logic [NUM_MASTER*DATA_WIDTH-1:0] m_hwdata,
   output logic [NUM_MASTER*DATA_WIDTH-1:0] m_hrdata,
   output logic [NUM_MASTER-1:0]            m_hready,
   output logic [NUM_MASTER-1:0]            m_hresp,
   output logic [NUM_SLAVES-1:0]            s_hsel,
   output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_haddr,
   output logic [NUM_SLAVES*2-1:0]          s_htrans,
   output logic [NUM_SLAVES-1:0]            s_hwrite,
   output logic [NUM_SLAVES*3-1:0]          s_hsize,
   output logic [NUM_SLAVES*3-1:0]          s_hburst,
   output logic [NUM_SLAVES*4-1:0]          s_hprot,
   output logic [NUM_SLAVES-1:0]            s_hmastlock,
   output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hwdata,
   output logic [NUM_SLAVES-1:0]            s_hready,
   input  logic [NUM_SLAVES-1:0]            s_hreadyout,
   input  logic [NUM_SLAVES-1:0]            s_hresp,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata
);
   localparam int M  = NUM_MASTER;
   localparam int S  = NUM_SLAVES;
   localparam int MW = (M > 1) ? $clog2(M) : 1;
   localparam int TW = $clog2(S + 1);
   localparam int CW = 14;
   // target code S denotes the internal default slave
   localparam logic [TW-1:0] DS = TW'(S);

   // control bundle layout: {htrans[1:0], hwrite, hsize[2:0], hburst[2:0], hprot[3:0], hmastlock}
   logic                  r_pv    [M];
   logic [ADDR_WIDTH-1:0] r_paddr [M];
   logic [CW-1:0]         r_pctl  [M];
   logic [TW-1:0]         r_ptgt  [M];
   logic [1:0]            r_ds    [M];
   logic                  r_dv    [S];
   logic [MW-1:0]         r_down  [S];
   logic [MW-1:0]         r_ptr   [S];
   logic                  r_lv    [S];
   logic [MW-1:0]         r_lown  [S];

   logic [ADDR_WIDTH-1:0] w_laddr [M];
   logic [CW-1:0]         w_lctl  [M];
   logic [TW-1:0]         w_ltgt  [M];
   logic                  w_live  [M];
   logic [ADDR_WIDTH-1:0] w_saddr [M];
   logic [CW-1:0]         w_sctl  [M];
   logic [TW-1:0]         w_stgt  [M];
   logic                  w_sreq  [M];
   logic                  w_mgnt  [M];
   logic                  w_avail [S];
   logic                  w_gnt   [S];
   logic [MW-1:0]         w_win   [S];

   // per-master decode and request selection; a valid pending phase masks the live inputs
   always_comb begin
      for (int i = 0; i < M; i++) begin
         w_laddr[i] = m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
         w_lctl[i]  = {m_htrans[i*2 +: 2], m_hwrite[i], m_hsize[i*3 +: 3], m_hburst[i*3 +: 3],
                       m_hprot[i*4 +: 4], m_hmastlock[i]};
         w_ltgt[i]  = DS;
         // descending scan leaves the lowest matching slave
         for (int j = S - 1; j >= 0; j--)
            if (w_laddr[i] >= SLAVE_BASE[j*ADDR_WIDTH +: ADDR_WIDTH] &&
                w_laddr[i] <= SLAVE_LAST[j*ADDR_WIDTH +: ADDR_WIDTH])
               w_ltgt[i] = TW'(j);
         w_live[i]  = !HRESET && !r_pv[i] && m_hready[i] && m_htrans[i*2+1];
         w_saddr[i] = r_pv[i] ? r_paddr[i] : w_laddr[i];
         w_sctl[i]  = r_pv[i] ? r_pctl[i] : w_lctl[i];
         w_stgt[i]  = r_pv[i] ? r_ptgt[i] : w_ltgt[i];
         w_sreq[i]  = (r_pv[i] || w_live[i]) && w_stgt[i] != DS;
      end
   end

   // per-slave round-robin starting after the last winner; a locked slave admits only its owner
   always_comb begin
      int n;
      n = 0;
      for (int j = 0; j < S; j++) begin
         w_avail[j] = !r_dv[j] || s_hreadyout[j];
         w_gnt[j]   = 1'b0;
         w_win[j]   = '0;
         for (int k = 1; k <= M; k++) begin
            n = int'(r_ptr[j]) + k;
            if (n >= M) n = n - M;
            if (!w_gnt[j] && w_avail[j] && w_sreq[n] && w_stgt[n] == TW'(j) &&
                (!r_lv[j] || r_lown[j] == MW'(n))) begin
               w_gnt[j] = 1'b1;
               w_win[j] = MW'(n);
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < M; i++) begin
         w_mgnt[i] = 1'b0;
         for (int j = 0; j < S; j++)
            if (w_gnt[j] && w_win[j] == MW'(i)) w_mgnt[i] = 1'b1;
      end
   end

   // slave-side address phase from the winner, write data from the data-phase owner
   always_comb begin
      s_hsel      = '0;
      s_haddr     = '0;
      s_htrans    = '0;
      s_hwrite    = '0;
      s_hsize     = '0;
      s_hburst    = '0;
      s_hprot     = '0;
      s_hmastlock = '0;
      s_hwdata    = '0;
      s_hready    = '1;
      for (int j = 0; j < S; j++) begin
         s_hready[j] = r_dv[j] ? s_hreadyout[j] : 1'b1;
         if (r_dv[j]) s_hwdata[j*DATA_WIDTH +: DATA_WIDTH] = m_hwdata[int'(r_down[j])*DATA_WIDTH +: DATA_WIDTH];
         if (w_gnt[j]) begin
            s_hsel[j] = 1'b1;
            s_haddr[j*ADDR_WIDTH +: ADDR_WIDTH] = w_saddr[w_win[j]] - SLAVE_BASE[j*ADDR_WIDTH +: ADDR_WIDTH];
            {s_htrans[j*2 +: 2], s_hwrite[j], s_hsize[j*3 +: 3], s_hburst[j*3 +: 3],
             s_hprot[j*4 +: 4], s_hmastlock[j]} = w_sctl[w_win[j]];
         end
      end
   end

   // master response: pending stalls, default slave ERROR, owned slave data phase, else zero-wait OKAY
   always_comb begin
      m_hready = '1;
      m_hresp  = '0;
      m_hrdata = '0;
      for (int i = 0; i < M; i++) begin
         if (r_pv[i]) m_hready[i] = 1'b0;
         else if (r_ds[i] != 2'd0) begin
            m_hready[i] = r_ds[i][1];
            m_hresp[i]  = 1'b1;
         end else
            for (int j = 0; j < S; j++)
               if (r_dv[j] && r_down[j] == MW'(i)) begin
                  m_hready[i] = s_hreadyout[j];
                  m_hresp[i]  = s_hresp[j];
                  m_hrdata[i*DATA_WIDTH +: DATA_WIDTH] = s_hrdata[j*DATA_WIDTH +: DATA_WIDTH];
               end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         for (int i = 0; i < M; i++) begin
            r_pv[i]    <= 1'b0;
            r_paddr[i] <= '0;
            r_pctl[i]  <= '0;
            r_ptgt[i]  <= '0;
            r_ds[i]    <= 2'd0;
         end
         for (int j = 0; j < S; j++) begin
            r_dv[j]   <= 1'b0;
            r_down[j] <= '0;
            r_ptr[j]  <= MW'(M - 1);
            r_lv[j]   <= 1'b0;
            r_lown[j] <= '0;
         end
      end else begin
         for (int i = 0; i < M; i++) begin
            if (r_pv[i] && w_mgnt[i]) r_pv[i] <= 1'b0;
            else if (w_live[i] && w_ltgt[i] != DS && !w_mgnt[i]) begin
               r_pv[i]    <= 1'b1;
               r_paddr[i] <= w_laddr[i];
               r_pctl[i]  <= w_lctl[i];
               r_ptgt[i]  <= w_ltgt[i];
            end
            // 1 = first ERROR cycle (wait), 2 = second ERROR cycle (ready)
            r_ds[i] <= (r_ds[i] == 2'd1) ? 2'd2 : (w_live[i] && w_ltgt[i] == DS) ? 2'd1 : 2'd0;
         end
         for (int j = 0; j < S; j++) begin
            if (w_avail[j]) begin
               r_dv[j]   <= w_gnt[j];
               r_down[j] <= w_win[j];
            end
            if (w_gnt[j]) r_ptr[j] <= w_win[j];
            if (w_gnt[j] && w_sctl[w_win[j]][0]) begin
               r_lv[j]   <= 1'b1;
               r_lown[j] <= w_win[j];
            end else if (r_lv[j] && m_hready[r_lown[j]] && !m_hmastlock[r_lown[j]])
               r_lv[j] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ahb_rr_matrix.sv
// tb_ahb_rr_matrix: directed scenario bench for the 2-master, 4-slave configuration of ahb_rr_matrix
module tb_ahb_rr_matrix;
   localparam logic [127:0] BASE = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h0000_0000};
   localparam logic [127:0] LAST = {32'h4FFF_FFFF, 32'h3FFF_FFFF, 32'h2FFF_FFFF, 32'h0FFF_FFFF};

   logic         HCLK, HRESET;
   logic [63:0]  m_haddr, m_hwdata, m_hrdata;
   logic [3:0]   m_htrans;
   logic [1:0]   m_hwrite, m_hmastlock, m_hready, m_hresp;
   logic [5:0]   m_hsize, m_hburst;
   logic [7:0]   m_hprot;
   logic [3:0]   s_hsel, s_hwrite, s_hmastlock, s_hready, s_hreadyout, s_hresp;
   logic [127:0] s_haddr, s_hwdata, s_hrdata;
   logic [7:0]   s_htrans;
   logic [11:0]  s_hsize, s_hburst;
   logic [15:0]  s_hprot;
   int checks = 0;
   int failures = 0;

   ahb_rr_matrix #(.NUM_MASTER(2), .NUM_SLAVES(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
                   .SLAVE_BASE(BASE), .SLAVE_LAST(LAST)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
      .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hmastlock(m_hmastlock), .m_hwdata(m_hwdata),
      .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
      .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
      .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hmastlock(s_hmastlock),
      .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp),
      .s_hrdata(s_hrdata)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic drv(input int i, input logic [1:0] tr, input logic [31:0] a, input logic w, input logic lk);
      m_htrans[i*2 +: 2]  = tr;
      m_haddr[i*32 +: 32] = a;
      m_hwrite[i]         = w;
      m_hmastlock[i]      = lk;
   endtask

   task automatic idle();
      drv(0, 2'b00, 32'h0, 1'b0, 1'b0);
      drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic nxt();
      @(posedge HCLK);
      #1;
   endtask

   task automatic smp();
      @(negedge HCLK);
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      drv(0, 2'b10, 32'h0000_0040, 1'b0, 1'b0);
      drv(1, 2'b10, 32'hF000_0000, 1'b0, 1'b0);
      smp();
      checks++; if (m_hready !== 2'b11) begin failures++; $display("FAIL rst_hready got=%b exp=11", m_hready); end
      checks++; if (m_hresp !== 2'b00) begin failures++; $display("FAIL rst_hresp got=%b exp=00", m_hresp); end
      checks++; if (s_hsel !== 4'b0000) begin failures++; $display("FAIL rst_hsel got=%b exp=0000", s_hsel); end
      checks++; if (s_hready !== 4'b1111) begin failures++; $display("FAIL rst_s_hready got=%b exp=1111", s_hready); end
      checks++; if (s_htrans !== 8'h00) begin failures++; $display("FAIL rst_s_htrans got=%h exp=00", s_htrans); end
      checks++; if (m_hrdata !== 64'h0) begin failures++; $display("FAIL rst_hrdata got=%h exp=0", m_hrdata); end
      nxt();
      HRESET = 1'b0;
      drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
      smp();
      checks++; if (s_hsel !== 4'b0001) begin failures++; $display("FAIL rel_hsel got=%b exp=0001", s_hsel); end
      checks++; if (s_haddr[31:0] !== 32'h40) begin failures++; $display("FAIL rel_haddr got=%h exp=40", s_haddr[31:0]); end
      checks++; if (s_htrans[1:0] !== 2'b10) begin failures++; $display("FAIL rel_htrans got=%b exp=10", s_htrans[1:0]); end
      nxt();
      idle();
      smp();
      checks++; if (m_hrdata[31:0] !== 32'h5A5A_0000) begin failures++; $display("FAIL rel_hrdata got=%h exp=5a5a0000", m_hrdata[31:0]); end
      nxt();
   endtask

   task automatic test_single_write();
      drv(0, 2'b10, 32'h2000_0010, 1'b1, 1'b0);
      smp();
      checks++; if (s_hsel !== 4'b0010) begin failures++; $display("FAIL wr_hsel got=%b exp=0010", s_hsel); end
      checks++; if (s_haddr[63:32] !== 32'h10) begin failures++; $display("FAIL wr_haddr got=%h exp=10", s_haddr[63:32]); end
      checks++; if (s_hwrite[1] !== 1'b1) begin failures++; $display("FAIL wr_hwrite got=%b exp=1", s_hwrite[1]); end
      nxt();
      idle();
      m_hwdata[31:0] = 32'hDEAD_BEEF;
      smp();
      checks++; if (s_hwdata[63:32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_hwdata got=%h exp=deadbeef", s_hwdata[63:32]); end
      checks++; if (m_hready[0] !== 1'b1) begin failures++; $display("FAIL wr_hready got=%b exp=1", m_hready[0]); end
      nxt();
      smp();
      checks++; if (s_hwdata[63:32] !== 32'h0) begin failures++; $display("FAIL wr_hwdata_clr got=%h exp=0", s_hwdata[63:32]); end
      nxt();
   endtask

   task automatic test_contention();
      drv(0, 2'b10, 32'h3000_0004, 1'b0, 1'b0);
      drv(1, 2'b10, 32'h3000_0008, 1'b0, 1'b0);
      smp();
      checks++; if (s_hsel !== 4'b0100) begin failures++; $display("FAIL ct_a_hsel got=%b exp=0100", s_hsel); end
      checks++; if (s_haddr[95:64] !== 32'h4) begin failures++; $display("FAIL ct_a_haddr got=%h exp=4", s_haddr[95:64]); end
      checks++; if (m_hready !== 2'b11) begin failures++; $display("FAIL ct_a_hready got=%b exp=11", m_hready); end
      nxt();
      drv(0, 2'b10, 32'h3000_000C, 1'b0, 1'b0);
      drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
      smp();
      checks++; if (s_haddr[95:64] !== 32'h8) begin failures++; $display("FAIL ct_b_haddr got=%h exp=8", s_haddr[95:64]); end
      checks++; if (m_hready !== 2'b01) begin failures++; $display("FAIL ct_b_hready got=%b exp=01", m_hready); end
      checks++; if (m_hrdata[31:0] !== 32'h5A5A_0002) begin failures++; $display("FAIL ct_b_hrdata got=%h exp=5a5a0002", m_hrdata[31:0]); end
      nxt();
      idle();
      smp();
      checks++; if (s_haddr[95:64] !== 32'hC) begin failures++; $display("FAIL ct_c_haddr got=%h exp=c", s_haddr[95:64]); end
      checks++; if (m_hready !== 2'b10) begin failures++; $display("FAIL ct_c_hready got=%b exp=10", m_hready); end
      nxt();
      smp();
      checks++; if (m_hready !== 2'b11) begin failures++; $display("FAIL ct_d_hready got=%b exp=11", m_hready); end
      checks++; if (s_hsel !== 4'b0000) begin failures++; $display("FAIL ct_d_hsel got=%b exp=0000", s_hsel); end
      nxt();
      drv(0, 2'b10, 32'h3000_0010, 1'b0, 1'b0);
      drv(1, 2'b10, 32'h3000_0020, 1'b0, 1'b0);
      smp();
      checks++; if (s_haddr[95:64] !== 32'h20) begin failures++; $display("FAIL ct_e_haddr got=%h exp=20", s_haddr[95:64]); end
      nxt();
      idle();
      smp();
      checks++; if (s_haddr[95:64] !== 32'h10) begin failures++; $display("FAIL ct_f_haddr got=%h exp=10", s_haddr[95:64]); end
      checks++; if (m_hready !== 2'b10) begin failures++; $display("FAIL ct_f_hready got=%b exp=10", m_hready); end
      nxt();
      nxt();
   endtask

   task automatic test_unmapped();
      drv(1, 2'b10, 32'hF000_0000, 1'b0, 1'b0);
      smp();
      checks++; if (s_hsel !== 4'b0000) begin failures++; $display("FAIL um_hsel got=%b exp=0000", s_hsel); end
      nxt();
      idle();
      smp();
      checks++; if ({m_hready[1], m_hresp[1]} !== 2'b01) begin failures++; $display("FAIL um_c1 got=%b exp=01", {m_hready[1], m_hresp[1]}); end
      checks++; if (s_hsel !== 4'b0000) begin failures++; $display("FAIL um_c1_hsel got=%b exp=0000", s_hsel); end
      nxt();
      smp();
      checks++; if ({m_hready[1], m_hresp[1]} !== 2'b11) begin failures++; $display("FAIL um_c2 got=%b exp=11", {m_hready[1], m_hresp[1]}); end
      nxt();
      smp();
      checks++; if ({m_hready, m_hresp} !== 4'b1100) begin failures++; $display("FAIL um_done got=%b exp=1100", {m_hready, m_hresp}); end
      nxt();
   endtask

   task automatic test_lock();
      drv(0, 2'b10, 32'h4000_0000, 1'b0, 1'b1);
      smp();
      checks++; if (s_hmastlock[3] !== 1'b1) begin failures++; $display("FAIL lk_mastlock got=%b exp=1", s_hmastlock[3]); end
      nxt();
      for (int b = 1; b <= 3; b++) begin
         drv(0, 2'b11, 32'h4000_0000 + 32'(b * 4), 1'b0, 1'b1);
         if (b == 1) drv(1, 2'b10, 32'h4000_0100, 1'b0, 1'b0);
         else drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
         smp();
         checks++; if (s_haddr[127:96] !== 32'(b * 4)) begin failures++; $display("FAIL lk_beat%0d_haddr got=%h exp=%h", b, s_haddr[127:96], b * 4); end
         checks++; if (m_hready[1] !== (b == 1)) begin failures++; $display("FAIL lk_beat%0d_m1_hready got=%b exp=%b", b, m_hready[1], b == 1); end
         nxt();
      end
      idle();
      smp();
      checks++; if (s_hsel !== 4'b0000) begin failures++; $display("FAIL lk_hold_hsel got=%b exp=0000", s_hsel); end
      checks++; if (m_hready[1] !== 1'b0) begin failures++; $display("FAIL lk_hold_hready got=%b exp=0", m_hready[1]); end
      nxt();
      smp();
      checks++; if (s_hsel !== 4'b1000) begin failures++; $display("FAIL lk_rel_hsel got=%b exp=1000", s_hsel); end
      checks++; if (s_haddr[127:96] !== 32'h100) begin failures++; $display("FAIL lk_rel_haddr got=%h exp=100", s_haddr[127:96]); end
      checks++; if (s_hmastlock[3] !== 1'b0) begin failures++; $display("FAIL lk_rel_mastlock got=%b exp=0", s_hmastlock[3]); end
      nxt();
      smp();
      checks++; if (m_hready[1] !== 1'b1) begin failures++; $display("FAIL lk_done_hready got=%b exp=1", m_hready[1]); end
      nxt();
   endtask

   task automatic test_wait();
      drv(0, 2'b10, 32'h0000_0100, 1'b0, 1'b0);
      nxt();
      idle();
      drv(1, 2'b10, 32'h0000_0200, 1'b0, 1'b0);
      s_hreadyout[0] = 1'b0;
      smp();
      checks++; if (m_hready !== 2'b10) begin failures++; $display("FAIL wt_1_hready got=%b exp=10", m_hready); end
      checks++; if (s_hready[0] !== 1'b0) begin failures++; $display("FAIL wt_1_s_hready got=%b exp=0", s_hready[0]); end
      checks++; if (s_hsel !== 4'b0000) begin failures++; $display("FAIL wt_1_hsel got=%b exp=0000", s_hsel); end
      nxt();
      idle();
      for (int c = 2; c <= 3; c++) begin
         smp();
         checks++; if (m_hready !== 2'b00) begin failures++; $display("FAIL wt_%0d_hready got=%b exp=00", c, m_hready); end
         checks++; if (s_hsel !== 4'b0000) begin failures++; $display("FAIL wt_%0d_hsel got=%b exp=0000", c, s_hsel); end
         nxt();
      end
      s_hreadyout[0] = 1'b1;
      smp();
      checks++; if (m_hready !== 2'b01) begin failures++; $display("FAIL wt_4_hready got=%b exp=01", m_hready); end
      checks++; if (s_hsel !== 4'b0001) begin failures++; $display("FAIL wt_4_hsel got=%b exp=0001", s_hsel); end
      checks++; if (s_haddr[31:0] !== 32'h200) begin failures++; $display("FAIL wt_4_haddr got=%h exp=200", s_haddr[31:0]); end
      checks++; if (m_hrdata[31:0] !== 32'h5A5A_0000) begin failures++; $display("FAIL wt_4_hrdata got=%h exp=5a5a0000", m_hrdata[31:0]); end
      nxt();
      smp();
      checks++; if (m_hready !== 2'b11) begin failures++; $display("FAIL wt_5_hready got=%b exp=11", m_hready); end
      nxt();
   endtask

   task automatic test_reset_mid();
      drv(0, 2'b10, 32'h2000_0000, 1'b0, 1'b0);
      drv(1, 2'b10, 32'h2000_0004, 1'b0, 1'b0);
      smp();
      checks++; if (s_haddr[63:32] !== 32'h4) begin failures++; $display("FAIL rm_win_haddr got=%h exp=4", s_haddr[63:32]); end
      nxt();
      idle();
      smp();
      checks++; if (m_hready[0] !== 1'b0) begin failures++; $display("FAIL rm_pend_hready got=%b exp=0", m_hready[0]); end
      #1;
      HRESET = 1'b1;
      #1;
      checks++; if (m_hready !== 2'b11) begin failures++; $display("FAIL rm_async_hready got=%b exp=11", m_hready); end
      checks++; if (s_hsel !== 4'b0000) begin failures++; $display("FAIL rm_async_hsel got=%b exp=0000", s_hsel); end
      nxt();
      HRESET = 1'b0;
      smp();
      checks++; if (m_hready !== 2'b11) begin failures++; $display("FAIL rm_after_hready got=%b exp=11", m_hready); end
      checks++; if (s_hsel !== 4'b0000) begin failures++; $display("FAIL rm_after_hsel got=%b exp=0000", s_hsel); end
      nxt();
      drv(1, 2'b10, 32'h2000_0030, 1'b0, 1'b0);
      smp();
      checks++; if (s_hsel !== 4'b0010) begin failures++; $display("FAIL rm_new_hsel got=%b exp=0010", s_hsel); end
      checks++; if (s_haddr[63:32] !== 32'h30) begin failures++; $display("FAIL rm_new_haddr got=%h exp=30", s_haddr[63:32]); end
      nxt();
      idle();
      nxt();
   endtask

   initial begin
      HRESET = 1'b1;
      m_haddr = '0; m_htrans = '0; m_hwrite = '0; m_hsize = 6'b010_010; m_hburst = '0;
      m_hprot = 8'h33; m_hmastlock = '0; m_hwdata = '0;
      s_hreadyout = 4'b1111; s_hresp = '0;
      for (int j = 0; j < 4; j++) s_hrdata[j*32 +: 32] = 32'h5A5A_0000 + 32'(j);
      test_reset();
      test_single_write();
      test_contention();
      test_unmapped();
      test_lock();
      test_wait();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ahb_rr_matrix.md
# ahb_rr_matrix

Parametrised AHB-Lite multi-master, multi-slave interconnect with per-slave round-robin arbitration, per-port data-phase tracking, and a stalled-request holding register per master. A losing master's transfer is buffered rather than dropped. Locked transfers keep their slave. Unmapped NONSEQ/SEQ accesses get a spec-compliant two-cycle ERROR from an internal default slave. The block sits between the CPU/DMA masters and the memory/peripheral slaves, using flattened vector ports.

## Interface
Parameters:
- NUM_MASTER, 2: master port count (1..8).
- NUM_SLAVES, 8: slave port count (1..16).
- DATA_WIDTH, 32: HWDATA/HRDATA width.
- ADDR_WIDTH, 32: HADDR width.
- SLAVE_BASE, 0: NUM_SLAVES*ADDR_WIDTH flattened first addresses; slave j at slice j.
- SLAVE_LAST, 0: NUM_SLAVES*ADDR_WIDTH flattened last addresses (inclusive).

Ports (M = NUM_MASTER, S = NUM_SLAVES, flattened, index i/j at slice i/j):
- HCLK  in  1  bus clock.
- HRESET  in  1  reset; one clock; reset is asynchronous and active-high.
- m_haddr  in  M*ADDR_WIDTH  master address.
- m_htrans  in  M*2  master transfer type.
- m_hwrite  in  M  master write.
- m_hsize  in  M*3  master size.
- m_hburst  in  M*3  master burst.
- m_hprot  in  M*4  master protection.
- m_hmastlock  in  M  master lock.
- m_hwdata  in  M*DATA_WIDTH  master write data.
- m_hrdata  out  M*DATA_WIDTH  read data to master.
- m_hready  out  M  HREADY to master.
- m_hresp  out  M  HRESP to master.
- s_hsel  out  S  slave select.
- s_haddr  out  S*ADDR_WIDTH  slave-relative address.
- s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot, s_hmastlock  out  S*(2,1,3,3,4,1)  forwarded control.
- s_hwdata  out  S*DATA_WIDTH  write data.
- s_hready  out  S  HREADY input of slave.
- s_hreadyout  in  S  slave HREADYOUT.
- s_hresp  in  S  slave HRESP.
- s_hrdata  in  S*DATA_WIDTH  slave read data.

## Operation
Decode:
- Target = lowest j with SLAVE_BASE[j] <= haddr <= SLAVE_LAST[j].
- No match targets the default slave (DS).

Master request rules:
- A live request is m_hready[i]=1 with htrans[i][1]=1.
- The pending register pend[i] holds a captured address phase: all control bits plus target.
- While pend[i] is valid, live inputs of master i are ignored.

Slave availability:
- Slave j is available when its data-phase owner register dp_own[j] is empty, or when s_hreadyout[j]=1.

Arbitration (per slave):
- Requesters are masters whose pend (priority) or live request targets j.
- Winner is the first requester at index ptr[j]+1, ptr[j]+2, ... modulo M.
- ptr[j] is set to the winner index on every grant.
- If lock[j] is valid, only lock[j]'s master may be granted.

Grant:
- The winner's phase is driven to slave j with s_hsel=1 and s_haddr = haddr - SLAVE_BASE[j] (ADDR_WIDTH wrap).
- dp_own[j] is set to the winner on the next edge.
- pend[winner] is cleared.
- lock[j] is set to the winner when hmastlock=1.
- lock[j] is cleared when its master presents any address phase (m_hready=1) with hmastlock=0.

Blocked requests:
- A live request that loses arbitration, or targets an unavailable slave, is captured into pend[i].

Master response mux:
- Master with pend valid: m_hready=0, m_hresp=0.
- Master owning a slave data phase: m_hready/m_hresp/m_hrdata come from that slave.
- Master otherwise: m_hready=1, m_hresp=0, m_hrdata=0.

Slave write side:
- s_hwdata[j] comes from master dp_own[j].
- s_hready[j] = s_hreadyout[j] when dp_own[j] is valid, else 1.

Default slave:
- Unmapped NONSEQ/SEQ needs no arbitration.
- Data cycle 1: m_hready=0, m_hresp=1. Cycle 2: m_hready=1, m_hresp=1.

Non-forwarded traffic:
- IDLE and BUSY are never forwarded (s_hsel=0).
- They get a zero-wait OKAY.

## Timing
- Reset values: m_hready all 1; m_hresp 0; m_hrdata 0; s_hsel 0; s_htrans 0; s_haddr and s_hwdata 0; s_hready all 1; ptr[j]=M-1 (master 0 first); pend, dp_own, lock and DS state cleared.
- Uncontended grant: 0 added cycles; the address phase is forwarded in the same cycle.
- Pending grant: earliest the cycle after capture. The master sees at least 1 extra wait state per blocked cycle.
- Simultaneous requests from multiple masters to the same slave: exactly one is granted; the others go pending.
- Pending beats live for the same slave only within the round-robin order. A pending master is never starved: at most M-1 grants occur before it is served, unless the slave is locked.
- Slave ERROR (two-cycle) passes through unmodified.
- HRESET mid-transfer: all in-flight and pending transfers are abandoned and outputs return to reset values asynchronously.

## Test plan
- Reset: assert HRESET with traffic active → m_hready=all 1, s_hsel=0, pend cleared; after release, master 0 NONSEQ to slave 0 is forwarded in the same cycle.
- Single write: M0 NONSEQ write haddr=0x2000_0010 to slave 1 (base 0x2000_0000), hwdata=0xDEADBEEF → s_hsel[1]=1, s_haddr=0x10, next cycle s_hwdata[1]=0xDEADBEEF, m_hready[0]=1.
- Contention: M0 and M1 NONSEQ to slave 2 in the same cycle → M0 forwarded, M1 m_hready=0, M1 forwarded the next cycle. Repeat both → M1 wins (round-robin).
- Unmapped: M1 NONSEQ to 0xF000_0000 → cycle 1 hready=0/hresp=1, cycle 2 hready=1/hresp=1, s_hsel all 0.
- Lock: M0 three locked SEQ beats to slave 3 while M1 requests slave 3 → M1 held pending until M0 presents hmastlock=0, then granted.
- Wait states: slave 0 holds hreadyout=0 for 3 cycles → owning master m_hready=0 for 3 cycles; a new request to slave 0 goes pending until hreadyout=1.
